// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings (common with the transmitter),
// default frame parameters and the idle line level.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned DATA_BITS_DEF  = 8;

    localparam logic IDLE_LEVEL = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] ST_DATA  = 2'b10;
    localparam logic [1:0] ST_STOP  = 2'b11;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle
// level so a reset never looks like a start edge.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Shift the raw line through two flops.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= IDLE_LEVEL;
            r_sync <= IDLE_LEVEL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling, one-entry holding register,
// framing-error pulse, sticky overrun flag and good-frame counter.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk_slow,
    input  logic                 rst,
    input  logic                 clk_rx,
    input  logic                 Rx,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_ready,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic [1:0]           state_out,
    output logic [15:0]          test_out
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 w_rx_s;
    logic [1:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_ready;
    logic                 r_ferr;
    logic                 r_ovr;
    logic [15:0]          r_count;

    uart_rx_sync u_sync (
        .i_clk   (clk_slow),
        .i_rst   (rst),
        .i_async (Rx),
        .o_sync  (w_rx_s)
    );

    // Receive FSM, sample/bit counters, holding register and status flags.
    // The handshake clear is written before the FSM so that a byte landing in
    // the same cycle as rd_ack leaves data_ready set.
    always_ff @(posedge clk_slow) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
            r_count <= '0;
        end else begin
            r_ferr <= 1'b0;
            if (r_ready && rd_ack) begin
                r_ready <= 1'b0;
            end
            if (clk_rx) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_rx_s) begin
                            r_state <= ST_START;
                            r_cnt   <= '0;
                        end
                    end
                    ST_START: begin
                        if (r_cnt == HALF_LAST) begin
                            r_cnt <= '0;
                            r_bit <= '0;
                            r_state <= w_rx_s ? ST_IDLE : ST_DATA;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (r_cnt == FULL_LAST) begin
                            r_cnt   <= '0;
                            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                            if (r_bit == BIT_LAST) begin
                                r_state <= ST_STOP;
                            end else begin
                                r_bit <= r_bit + 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (r_cnt == FULL_LAST) begin
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                            if (w_rx_s) begin
                                r_data  <= r_shift;
                                r_ready <= 1'b1;
                                r_count <= r_count + 16'd1;
                                if (r_ready && !rd_ack) begin
                                    r_ovr <= 1'b1;
                                end
                            end else begin
                                r_ferr <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign data_out   = r_data;
    assign data_ready = r_ready;
    assign rx_busy    = (r_state != ST_IDLE);
    assign frame_err  = r_ferr;
    assign overrun    = r_ovr;
    assign state_out  = r_state;
    assign test_out   = r_count;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: a serial transmitter model drives Rx,
// expected bytes go into a scoreboard queue and are checked whenever the
// good-frame counter advances.
module tb_uart_receiver;

    logic        clk_slow;
    logic        rst;
    logic        clk_rx;
    logic        Rx;
    logic        rd_ack;
    logic [7:0]  data_out;
    logic        data_ready;
    logic        rx_busy;
    logic        frame_err;
    logic        overrun;
    logic [1:0]  state_out;
    logic [15:0] test_out;

    int          checks   = 0;
    int          failures = 0;
    int          fe_cnt   = 0;
    int          prev_cnt = 0;
    int unsigned tick_div = 3;
    logic [7:0]  exp_q[$];

    uart_receiver #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk_slow   (clk_slow),
        .rst        (rst),
        .clk_rx     (clk_rx),
        .Rx         (Rx),
        .rd_ack     (rd_ack),
        .data_out   (data_out),
        .data_ready (data_ready),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .state_out  (state_out),
        .test_out   (test_out)
    );

    initial clk_slow = 1'b0;
    always #5 clk_slow = ~clk_slow;

    // Oversampling tick: one cycle in every tick_div, or held high when tick_div is 1.
    initial begin
        int unsigned tc;
        tc = 0;
        clk_rx = 1'b0;
        forever begin
            @(negedge clk_slow);
            clk_rx = (tick_div <= 1) ? 1'b1 : (tc == 0);
            tc = (tick_div <= 1) ? 0 : (tc + 1) % tick_div;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every counter step must carry the next expected byte.
    always @(negedge clk_slow) begin
        logic [8:0] exp;
        if (frame_err === 1'b1) fe_cnt++;
        if (rst) begin
            prev_cnt = 0;
        end else if (int'(test_out) != prev_cnt) begin
            check("cnt_step", {16'd0, test_out}, 32'(16'(prev_cnt + 1)));
            exp = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
            check("sb_data", {23'd0, 1'b0, data_out}, {23'd0, exp});
            prev_cnt = int'(test_out);
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
        int unsigned bc;
        bc = 16 * tick_div;
        Rx = 1'b0;
        repeat (bc) @(negedge clk_slow);
        for (int i = 0; i < 8; i++) begin
            Rx = b[i];
            repeat (bc) @(negedge clk_slow);
        end
        Rx = stop_lvl;
        repeat (bc) @(negedge clk_slow);
        Rx = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk_slow);
        rst = 1'b0;
        @(negedge clk_slow);
    endtask

    initial begin
        #2ms;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int          fe0;
        logic [7:0]  b;
        rst = 1'b1;
        Rx = 1'b1;
        rd_ack = 1'b0;
        repeat (4) @(negedge clk_slow);
        check("rst_data_out", {24'd0, data_out}, 32'h00);
        check("rst_ready", {31'd0, data_ready}, 32'd0);
        check("rst_busy", {31'd0, rx_busy}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        check("rst_state", {30'd0, state_out}, 32'd0);
        check("rst_count", {16'd0, test_out}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk_slow);

        // Short low glitch: FSM enters START then drops back to IDLE.
        Rx = 1'b0;
        repeat (5 * tick_div) @(negedge clk_slow);
        check("glitch_busy", {31'd0, rx_busy}, 32'd1);
        Rx = 1'b1;
        repeat (32 * tick_div) @(negedge clk_slow);
        check("glitch_state", {30'd0, state_out}, 32'd0);
        check("glitch_idle", {31'd0, rx_busy}, 32'd0);
        check("glitch_ready", {31'd0, data_ready}, 32'd0);
        check("glitch_count", {16'd0, test_out}, 32'd0);

        // Framing error: stop bit low.
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (32 * tick_div) @(negedge clk_slow);
        check("ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
        check("ferr_ready", {31'd0, data_ready}, 32'd0);
        check("ferr_data", {24'd0, data_out}, 32'h00);
        check("ferr_count", {16'd0, test_out}, 32'd0);
        check("ferr_state", {30'd0, state_out}, 32'd0);

        // Good byte plus handshake.
        fe0 = fe_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        repeat (4) @(negedge clk_slow);
        check("a5_ready", {31'd0, data_ready}, 32'd1);
        check("a5_data", {24'd0, data_out}, 32'hA5);
        check("a5_count", {16'd0, test_out}, 32'd1);
        check("a5_no_ferr", 32'(fe_cnt - fe0), 32'd0);
        rd_ack = 1'b1;
        @(negedge clk_slow);
        rd_ack = 1'b0;
        check("ack_clear", {31'd0, data_ready}, 32'd0);
        rd_ack = 1'b1;
        @(negedge clk_slow);
        rd_ack = 1'b0;
        check("ack_idle_ready", {31'd0, data_ready}, 32'd0);
        check("ack_idle_data", {24'd0, data_out}, 32'hA5);

        // Overrun: two bytes, no acknowledge.
        do_reset();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (4) @(negedge clk_slow);
        check("ovr_data", {24'd0, data_out}, 32'h22);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        check("ovr_ready", {31'd0, data_ready}, 32'd1);
        check("ovr_count", {16'd0, test_out}, 32'd2);
        check("ovr_queue", 32'(exp_q.size()), 32'd0);

        // Same pair, rd_ack on the cycle the second byte lands.
        do_reset();
        tick_div = 1;
        repeat (2) @(negedge clk_slow);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1);
        fork
            send_frame(8'h22, 1'b1);
            begin
                int w;
                w = 0;
                while (state_out !== 2'b11 && w < 400) begin
                    @(negedge clk_slow);
                    w++;
                end
                check("wait_stop", {30'd0, state_out}, 32'd3);
                repeat (15) @(negedge clk_slow);
                rd_ack = 1'b1;
                @(negedge clk_slow);
                rd_ack = 1'b0;
            end
        join
        repeat (4) @(negedge clk_slow);
        check("sim_ack_ovr", {31'd0, overrun}, 32'd0);
        check("sim_ack_ready", {31'd0, data_ready}, 32'd1);
        check("sim_ack_data", {24'd0, data_out}, 32'h22);
        check("sim_ack_count", {16'd0, test_out}, 32'd2);

        // Reset in the middle of a 0xFF frame, then a clean 0x5A.
        Rx = 1'b0;
        repeat (16 * tick_div) @(negedge clk_slow);
        Rx = 1'b1;
        repeat (48 * tick_div) @(negedge clk_slow);
        check("abort_in_data", {30'd0, state_out}, 32'd2);
        rst = 1'b1;
        repeat (2) @(negedge clk_slow);
        rst = 1'b0;
        @(negedge clk_slow);
        check("abort_state", {30'd0, state_out}, 32'd0);
        check("abort_data", {24'd0, data_out}, 32'h00);
        check("abort_ready", {31'd0, data_ready}, 32'd0);
        check("abort_ovr", {31'd0, overrun}, 32'd0);
        check("abort_ferr", {31'd0, frame_err}, 32'd0);
        check("abort_count", {16'd0, test_out}, 32'd0);
        repeat (20) @(negedge clk_slow);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        repeat (4) @(negedge clk_slow);
        check("post_abort_data", {24'd0, data_out}, 32'h5A);
        check("post_abort_count", {16'd0, test_out}, 32'd1);

        // 256 random bytes, acknowledged after each.
        do_reset();
        fe0 = fe_cnt;
        for (int n = 0; n < 256; n++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            rd_ack = 1'b1;
            @(negedge clk_slow);
            rd_ack = 1'b0;
        end
        repeat (4) @(negedge clk_slow);
        check("rand_count", {16'd0, test_out}, 32'd256);
        check("rand_ovr", {31'd0, overrun}, 32'd0);
        check("rand_ferr", 32'(fe_cnt - fe0), 32'd0);
        check("rand_queue", 32'(exp_q.size()), 32'd0);
        check("rand_ready", {31'd0, data_ready}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
